// File: rtl/md_issue_ctrl_if.sv
// Handshake bundle between the D/E pipeline registers and the mult/div
// issue controller. The pipeline side drives the instruction words and
// qualifiers; the controller returns start/busy/done/stall/error status.
interface md_issue_ctrl_if;
    logic [31:0] d_instr;
    logic [31:0] e_instr;
    logic        e_valid;
    logic        flush;
    logic        md_start;
    logic        md_busy;
    logic [1:0]  md_kind;
    logic        md_done;
    logic        stall_d;
    logic        proto_err;

    modport master (
        output d_instr, e_instr, e_valid, flush,
        input  md_start, md_busy, md_kind, md_done, stall_d, proto_err
    );

    modport slave (
        input  d_instr, e_instr, e_valid, flush,
        output md_start, md_busy, md_kind, md_done, stall_d, proto_err
    );
endinterface

// File: rtl/md_issue_ctrl.sv
// Issue and hazard controller for the multiply/divide unit.
// Decodes the E-stage instruction, pulses a start for mult/multu/div/divu,
// times the operation with a down-counter and stalls HI/LO-class
// instructions in D while the unit is busy (including the issue cycle).
//
// state | meaning
// IDLE  | no operation in flight, issue allowed
// MUL   | mult/multu in flight, cnt counts down MULT_CYCLES..1
// DIV   | div/divu in flight, cnt counts down DIV_CYCLES..1
module md_issue_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    md_issue_ctrl_if.slave       bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10
    } state_t;

    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    state_t     state_q;
    logic [3:0] cnt_q;
    logic [1:0] kind_q;
    logic       busy_q;
    logic       perr_q;

    logic       d_md;
    logic       e_start;
    logic       e_is_div;
    logic       issue;

    // Only opcode and funct take part in decode; the register fields are don't-care.
    logic unused_bits;
    assign unused_bits = ^{bus.d_instr[25:6], bus.e_instr[25:6]};

    function automatic logic is_md_class(input logic [31:0] instr);
        return (instr[31:26] == 6'b000000) &&
               (instr[5:0] inside {6'b011000, 6'b011001, 6'b011010, 6'b011011,
                                   6'b010000, 6'b010010, 6'b010001, 6'b010011});
    endfunction

    function automatic logic is_start_class(input logic [31:0] instr);
        return (instr[31:26] == 6'b000000) && (instr[5:2] == 4'b0110);
    endfunction

    // Combinational decode of both stages and the issue qualifier; reset gates
    // issue so no start escapes while the block is held in reset.
    always_comb begin
        d_md     = is_md_class(bus.d_instr);
        e_start  = is_start_class(bus.e_instr);
        e_is_div = bus.e_instr[1];
        issue    = reset & bus.e_valid & ~bus.flush & e_start & (state_q == IDLE);
    end

    // Sequencer: load the latency on issue, count down to 1, then return to IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            kind_q  <= 2'b00;
            busy_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            // A start-class op reaching E while busy is dropped and flagged.
            if (e_start && bus.e_valid && busy_q) begin
                perr_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (issue) begin
                        busy_q <= 1'b1;
                        if (e_is_div) begin
                            state_q <= DIV;
                            cnt_q   <= DIV_N;
                            kind_q  <= 2'b10;
                        end else begin
                            state_q <= MUL;
                            cnt_q   <= MULT_N;
                            kind_q  <= 2'b01;
                        end
                    end
                end
                MUL, DIV: begin
                    if (cnt_q == 4'd1) begin
                        state_q <= IDLE;
                        cnt_q   <= 4'd0;
                        kind_q  <= 2'b00;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= 4'd0;
                    kind_q  <= 2'b00;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Outputs: done is the last busy cycle; stall covers issue plus busy window.
    always_comb begin
        bus.md_start  = issue;
        bus.md_busy   = busy_q;
        bus.md_kind   = kind_q;
        bus.md_done   = busy_q & (cnt_q == 4'd1);
        bus.stall_d   = d_md & (busy_q | issue);
        bus.proto_err = perr_q;
    end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Bench for md_issue_ctrl: combinational decode table, hand-written
// multi-cycle sequences and random traffic against a timeline model.
module tb_md_issue_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    localparam logic [31:0] I_MULT  = 32'h00850018;
    localparam logic [31:0] I_MULTU = 32'h00850019;
    localparam logic [31:0] I_DIV   = 32'h0085001a;
    localparam logic [31:0] I_DIVU  = 32'h0085001b;
    localparam logic [31:0] I_MFHI  = 32'h00000010;
    localparam logic [31:0] I_MFLO  = 32'h00001012;
    localparam logic [31:0] I_MTHI  = 32'h00800011;
    localparam logic [31:0] I_MTLO  = 32'h00000013;
    localparam logic [31:0] I_ADDU  = 32'h00851021;
    localparam logic [31:0] I_LWF   = 32'h8c850018;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    md_issue_ctrl_if bus ();

    md_issue_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (timeline of the last issue) ----------
    int cyc;
    int t_iss;
    int n_iss;
    int k_iss;
    bit m_perr;

    function automatic bit f_md(input logic [31:0] w);
        logic [5:0] fl [8];
        bit hit;
        fl = '{6'd24, 6'd25, 6'd26, 6'd27, 6'd16, 6'd18, 6'd17, 6'd19};
        hit = 0;
        for (int i = 0; i < 8; i++) if (w[5:0] == fl[i]) hit = 1;
        return (w[31:26] == 6'd0) && hit;
    endfunction

    function automatic bit f_start(input logic [31:0] w);
        return (w[31:26] == 6'd0) && (w[5:0] >= 6'd24) && (w[5:0] <= 6'd27);
    endfunction

    function automatic bit f_div(input logic [31:0] w);
        return (w[5:0] == 6'd26) || (w[5:0] == 6'd27);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        t_iss  = -1000;
        n_iss  = 0;
        k_iss  = 0;
        m_perr = 0;
    endtask

    // One clock cycle: drive at negedge, check outputs, advance the model.
    task automatic cycle(input logic [31:0] d, input logic [31:0] e, input logic v, input logic f);
        bit m_busy, m_done, m_issue, m_stall, e_st;
        int m_kind;
        @(negedge clk);
        bus.d_instr = d;
        bus.e_instr = e;
        bus.e_valid = v;
        bus.flush   = f;
        #1;
        m_busy  = (cyc > t_iss) && (cyc <= t_iss + n_iss);
        m_done  = m_busy && (cyc == t_iss + n_iss);
        m_kind  = m_busy ? k_iss : 0;
        e_st    = f_start(e);
        m_issue = v && !f && e_st && !m_busy;
        m_stall = f_md(d) && (m_busy || m_issue);
        chk("md_start",  32'(bus.md_start),  32'(m_issue));
        chk("md_busy",   32'(bus.md_busy),   32'(m_busy));
        chk("md_done",   32'(bus.md_done),   32'(m_done));
        chk("md_kind",   32'(bus.md_kind),   32'(m_kind));
        chk("stall_d",   32'(bus.stall_d),   32'(m_stall));
        chk("proto_err", 32'(bus.proto_err), 32'(m_perr));
        if (m_issue) begin
            t_iss = cyc;
            n_iss = f_div(e) ? DIV_N : MULT_N;
            k_iss = f_div(e) ? 2 : 1;
        end
        if (e_st && v && m_busy) m_perr = 1;
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        bus.e_valid = 1'b0;
        bus.flush   = 1'b0;
        bus.d_instr = 32'd0;
        bus.e_instr = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [31:0] d;
        logic [31:0] e;
        logic        v;
        logic        f;
        logic        start;
        logic        stall;
    } vec_t;

    vec_t tbl [10];
    logic [31:0] pool [11];

    initial begin
        errors = 0;
        checks = 0;
        cyc    = 0;
        model_reset();

        tbl[0] = '{d: 32'd0,   e: I_MULT,  v: 1, f: 0, start: 1, stall: 0};
        tbl[1] = '{d: I_MFLO,  e: I_MULT,  v: 1, f: 0, start: 1, stall: 1};
        tbl[2] = '{d: I_MFHI,  e: I_DIV,   v: 1, f: 1, start: 0, stall: 0};
        tbl[3] = '{d: I_MFHI,  e: I_DIVU,  v: 0, f: 0, start: 0, stall: 0};
        tbl[4] = '{d: I_MFLO,  e: I_LWF,   v: 1, f: 0, start: 0, stall: 0};
        tbl[5] = '{d: I_MTHI,  e: I_MTHI,  v: 1, f: 0, start: 0, stall: 0};
        tbl[6] = '{d: I_ADDU,  e: I_MULTU, v: 1, f: 0, start: 1, stall: 0};
        tbl[7] = '{d: I_LWF,   e: I_DIVU,  v: 1, f: 0, start: 1, stall: 0};
        tbl[8] = '{d: I_MTLO,  e: I_DIV,   v: 1, f: 0, start: 1, stall: 1};
        tbl[9] = '{d: I_MULT,  e: I_MFLO,  v: 1, f: 0, start: 0, stall: 0};

        // Held in reset with a mult in E: nothing may start.
        reset = 1'b0;
        bus.d_instr = I_MFLO;
        bus.e_instr = I_MULT;
        bus.e_valid = 1'b1;
        bus.flush   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_start", 32'(bus.md_start),  32'd0);
        chk("rst_busy",  32'(bus.md_busy),   32'd0);
        chk("rst_kind",  32'(bus.md_kind),   32'd0);
        chk("rst_perr",  32'(bus.proto_err), 32'd0);
        chk("rst_stall", 32'(bus.stall_d),   32'd0);
        chk("rst_done",  32'(bus.md_done),   32'd0);
        do_reset();

        // Decode table in IDLE; e_valid drops before the edge so no op issues.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.d_instr = tbl[i].d;
            bus.e_instr = tbl[i].e;
            bus.e_valid = tbl[i].v;
            bus.flush   = tbl[i].f;
            #1;
            chk($sformatf("tbl%0d_start", i), 32'(bus.md_start), 32'(tbl[i].start));
            chk($sformatf("tbl%0d_stall", i), 32'(bus.stall_d),  32'(tbl[i].stall));
            chk($sformatf("tbl%0d_busy", i),  32'(bus.md_busy),  32'd0);
            bus.e_valid = 1'b0;
        end

        // mult: 5 busy cycles, done in the 5th, back to IDLE after.
        cycle(32'd0, I_MULT, 1, 0);
        repeat (7) cycle(I_MFHI, 32'd0, 0, 0);

        // divu with mflo held in D: stall across issue plus 10 busy cycles.
        cycle(I_MFLO, I_DIVU, 1, 0);
        repeat (12) cycle(I_MFLO, 32'd0, 0, 0);

        // flush and bubble suppress issue.
        cycle(I_MFLO, I_DIV, 1, 1);
        cycle(I_MFLO, I_DIV, 0, 0);
        cycle(32'd0, 32'd0, 0, 0);

        // Async reset in the 2nd busy cycle, then a fresh div.
        cycle(I_MFLO, I_MULT, 1, 0);
        cycle(I_MFLO, 32'd0, 0, 0);
        cycle(I_MFLO, 32'd0, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        chk("async_busy",  32'(bus.md_busy), 32'd0);
        chk("async_kind",  32'(bus.md_kind), 32'd0);
        chk("async_stall", 32'(bus.stall_d), 32'd0);
        chk("async_done",  32'(bus.md_done), 32'd0);
        do_reset();
        cycle(I_MFLO, I_DIV, 1, 0);
        repeat (12) cycle(I_MFLO, 32'd0, 0, 0);

        // div in E during 3rd busy cycle of a mult: ignored, proto_err sticks.
        cycle(32'd0, I_MULT, 1, 0);
        cycle(32'd0, 32'd0, 0, 0);
        cycle(32'd0, 32'd0, 0, 0);
        cycle(I_ADDU, I_DIV, 1, 0);
        repeat (6) cycle(I_ADDU, 32'd0, 0, 0);
        chk("perr_sticky", 32'(bus.proto_err), 32'd1);
        do_reset();

        // Start-class op in the md_done cycle counts as busy.
        cycle(32'd0, I_MULTU, 1, 0);
        repeat (4) cycle(32'd0, 32'd0, 0, 0);
        cycle(I_MFHI, I_MULTU, 1, 0);
        repeat (3) cycle(I_MFHI, I_MULT, 1, 0);
        do_reset();

        // Random traffic.
        pool = '{I_MULT, I_MULTU, I_DIV, I_DIVU, I_MFHI, I_MFLO,
                 I_MTHI, I_MTLO, I_ADDU, I_LWF, 32'd0};
        for (int n = 0; n < 600; n++) begin
            logic [31:0] rd, re;
            rd = ($urandom_range(0, 7) == 0) ? $urandom : pool[$urandom_range(0, 10)];
            re = ($urandom_range(0, 7) == 0) ? $urandom : pool[$urandom_range(0, 10)];
            cycle(rd, re, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0));
            if (n == 300) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/md_issue_ctrl.md
# md_issue_ctrl

Issue and hazard controller for the pipeline's multiply/divide unit. It decodes the E-stage instruction, fires a one-cycle start to the unit for mult/multu/div/divu, and tracks the operation's latency with its own counter. While an operation is in flight, it stalls any HI/LO-class instruction sitting in D. It sits between the D/E pipeline registers and the mult/div unit, and its stall output is ORed into the global D-stage stall.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles after start for mult/multu (legal 1..15)
- DIV_CYCLES, 10, busy cycles after start for div/divu (legal 1..15)

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- d_instr  in  32  instruction word in D stage
- e_instr  in  32  instruction word in E stage
- e_valid  in  1  E stage holds a real instruction (0 = bubble)
- flush  in  1  E-stage instruction is being killed this cycle
- md_start  out  1  one-cycle start pulse to mult/div unit
- md_busy  out  1  operation in flight (state != IDLE)
- md_kind  out  2  00 none, 01 mult class, 10 div class; valid while md_busy
- md_done  out  1  one-cycle pulse in last busy cycle; HI/LO final at following edge
- stall_d  out  1  hold D stage
- proto_err  out  1  sticky: md op seen in E while busy

## Operation
- An instruction is MD-class when opcode [31:26] = 000000 and funct [5:0] ∈ {mult 011000, multu 011001, div 011010, divu 011011, mfhi 010000, mflo 010010, mthi 010001, mtlo 010011}.
- START-class is the subset mult, multu, div, divu. Both opcode and funct must match. Nonzero opcode with a matching funct is not MD-class.
- State machine states: IDLE, MUL, DIV. The 4-bit counter cnt is 0 in IDLE.
- issue = e_valid & !flush & START-class(e_instr) & state==IDLE.
- md_start = issue (combinational).
- Transitions:
  - IDLE, issue with mult/multu → MUL, cnt=MULT_CYCLES, md_kind=01.
  - IDLE, issue with div/divu → DIV, cnt=DIV_CYCLES, md_kind=10.
  - MUL/DIV, cnt>1 → cnt-1.
  - MUL/DIV, cnt==1 → md_done=1 this cycle; next IDLE, cnt=0, md_kind=00.
- md_busy = (state != IDLE), registered.
- stall_d = MD-class(d_instr) & (md_busy | md_start). This is combinational and covers the issue cycle, so a following mfhi/mult cannot enter E one cycle early.
- mfhi/mflo/mthi/mtlo in E never start the unit and never change state.
- If START-class(e_instr) & e_valid & md_busy, the op is ignored (no start, no restart) and proto_err is set. proto_err clears only on reset.
- flush suppresses issue in the same cycle only. An op already in flight is not cancelled by flush.

## Timing
- Reset values: md_start 0, md_busy 0, md_kind 00, md_done 0, stall_d 0 (when d_instr is non-MD), proto_err 0, state IDLE, cnt 0.
- Reset is asynchronous: asserting reset mid-operation drops md_busy/md_done/md_kind at once. Deasserting it gives IDLE from the next edge.
- Issue in cycle t:
  - mult/multu: busy in t+1..t+MULT_CYCLES, md_done at t+MULT_CYCLES, IDLE at t+MULT_CYCLES+1.
  - div/divu: the same with DIV_CYCLES.
- A new issue is legal in the first IDLE cycle. There is no back-to-back issue in the md_done cycle.
- stall_d is high in cycles t..t+N, N = MULT_CYCLES or DIV_CYCLES, whenever D holds an MD-class instruction. It falls in the first IDLE cycle.
- Simultaneous flush and START-class in E while IDLE: no start, state unchanged.
- Simultaneous md_done and a START-class op in E: treated as busy; proto_err is set.

## Test plan
- Reset low with e_instr=mult → md_start 0, md_busy 0, md_kind 00, proto_err 0. Release reset, then e_instr=0x00850018 (mult a0,a1) with e_valid=1 → md_start 1 for one cycle; md_busy high 5 cycles; md_done in 5th busy cycle; md_kind 01.
- divu (funct 011011) issued with d_instr=mflo (0x00001012) held → stall_d high for 11 cycles (issue + 10 busy); md_done on 10th busy cycle; stall_d low in the next cycle.
- flush=1 with div in E, IDLE → md_start 0, state stays IDLE. Same op with e_valid=0 → no issue.
- mult issued; reset pulsed low at 2nd busy cycle → md_busy, md_kind, stall_d drop asynchronously. After release, a fresh div issues normally with full DIV_CYCLES latency.
- mult busy; force e_instr=div with e_valid=1 at 3rd busy cycle → no md_start, cnt continues (done still at 5th cycle), proto_err=1 until reset.
- e_instr opcode 0x23 (lw) with funct bits 011000 → no start. mthi in E → no start. d_instr=addu while busy → stall_d 0.
